// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one registered-output ALU.
// req_* valid/ready in, rsp_* result pulse out, alu_* drive the ALU; busy, op_count.
package alu_package;
  typedef enum logic [3:0] {
    RST = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    AND = 4'd3,
    OR  = 4'd4,
    XOR = 4'd5,
    NOT = 4'd6,
    MOV = 4'd7,
    LSH = 4'd8,
    RSH = 4'd9
  } myopcode_t;
endpackage

module alu_rr_scheduler
  import alu_package::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  myopcode_t          req_opcode [NUM_REQ],
  input  logic [DATA_W-1:0]  req_a      [NUM_REQ],
  input  logic [DATA_W-1:0]  req_b      [NUM_REQ],
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [DATA_W-1:0]  rsp_data,
  output myopcode_t          alu_opcode,
  output logic [DATA_W-1:0]  alu_data_1,
  output logic [DATA_W-1:0]  alu_data_2,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               busy,
  output logic [15:0]        op_count
);

  localparam int          PW  = $clog2(NUM_REQ);
  localparam logic [PW:0] NR  = NUM_REQ[PW:0];
  localparam logic [2:0]  LAT = ALU_LAT[2:0];

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      gnt_q;
  logic [PW-1:0]      off;
  logic [PW-1:0]      gnt;
  logic [PW-1:0]      nxt;
  logic [PW:0]        sum;
  logic [PW:0]        sum1;
  logic [NUM_REQ-1:0] rot;
  logic               any;
  logic [2:0]         cnt_q;

  // Rotate so ptr lands on bit 0; the lowest set
  // bit of the rotated vector is the winner.
  always_comb begin
    rot = NUM_REQ'({req_valid, req_valid} >> ptr_q);
    any = 1'b0;
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        any = 1'b1;
        off = PW'(i);
      end
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= NR) sum = sum - NR;
    gnt  = sum[PW-1:0];
    sum1 = {1'b0, gnt} + (PW+1)'(1);
    if (sum1 == NR) sum1 = '0;
    nxt = sum1[PW-1:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  assign req_ready = (state_q == IDLE && any)
                   ? (NUM_REQ'(1) << gnt)
                   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      gnt_q      <= '0;
      cnt_q      <= '0;
      alu_opcode <= RST;
      alu_data_1 <= '0;
      alu_data_2 <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      op_count   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any) begin
            alu_opcode <= req_opcode[gnt];
            alu_data_1 <= req_a[gnt];
            alu_data_2 <= req_b[gnt];
            ptr_q      <= nxt;
            gnt_q      <= gnt;
            cnt_q      <= LAT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            rsp_data  <= alu_result;
            rsp_valid <= NUM_REQ'(1) << gnt_q;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RESP: begin
          rsp_valid  <= '0;
          op_count   <= op_count + 16'd1;
          alu_opcode <= RST;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: two schedulers (ALU_LAT 1 and 3) on ALU models.
// Timeline model checks the LAT=1 unit every cycle; directed literals pin both.
module tb_alu_rr_scheduler;
  import alu_package::*;

  localparam int N    = 4;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(myopcode_t op, logic [7:0] a,
                                        logic [7:0] b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      NOT:     return ~a;
      MOV:     return a;
      LSH:     return a << 4;
      RSH:     return a >> 4;
      default: return 8'h00;
    endcase
  endfunction

  myopcode_t   op1 [N];
  logic [7:0]  a1  [N];
  logic [7:0]  b1  [N];
  logic [3:0]  v1, rdy1, rv1;
  logic [7:0]  rd1, ad11, ad12, ar1;
  myopcode_t   ao1;
  logic        busy1;
  logic [15:0] cnt1;

  myopcode_t   op3 [N];
  logic [7:0]  a3  [N];
  logic [7:0]  b3  [N];
  logic [3:0]  v3, rdy3, rv3;
  logic [7:0]  rd3, ad31, ad32, ar3;
  myopcode_t   ao3;
  logic        busy3;
  logic [15:0] cnt3;
  logic [7:0]  p3 [3];

  alu_rr_scheduler #(.NUM_REQ(N), .DATA_W(8), .ALU_LAT(1)) d1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v1), .req_ready(rdy1),
    .req_opcode(op1), .req_a(a1), .req_b(b1),
    .rsp_valid(rv1), .rsp_data(rd1),
    .alu_opcode(ao1), .alu_data_1(ad11), .alu_data_2(ad12),
    .alu_result(ar1), .busy(busy1), .op_count(cnt1)
  );

  alu_rr_scheduler #(.NUM_REQ(N), .DATA_W(8), .ALU_LAT(3)) d3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v3), .req_ready(rdy3),
    .req_opcode(op3), .req_a(a3), .req_b(b3),
    .rsp_valid(rv3), .rsp_data(rd3),
    .alu_opcode(ao3), .alu_data_1(ad31), .alu_data_2(ad32),
    .alu_result(ar3), .busy(busy3), .op_count(cnt3)
  );

  always @(posedge clk) ar1 <= alu_fn(ao1, ad11, ad12);

  always @(posedge clk) begin
    p3[0] <= alu_fn(ao3, ad31, ad32);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign ar3 = p3[2];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  int         gq[$], gcq[$], rq[$], rcq[$];
  logic [7:0] rdq[$];
  int         g3q[$], g3cq[$], r3q[$], r3cq[$];
  logic [7:0] r3dq[$];
  logic [3:0] last_rdy1, last_rdy3;
  int         viol3 = 0;

  int          m_ptr = 0, m_free = 0, m_rsp = -1, m_idx = 0;
  logic [15:0] m_cnt = 0;
  myopcode_t   m_op = RST;
  logic [7:0]  m_a = 0, m_b = 0, m_val = 0;

  always @(negedge clk) begin : model
    logic       eb;
    logic [3:0] er, ers;
    int         g, bd, d;
    cyc++;
    if (!rst_n) begin
      chk("rst_ready", 32'(rdy1), 32'h0);
      chk("rst_rsp", 32'(rv1), 32'h0);
      chk("rst_busy", 32'(busy1), 32'h0);
      chk("rst_count", 32'(cnt1), 32'h0);
      chk("rst_opcode", 32'(ao1), 32'(RST));
      chk("rst_data1", 32'(ad11), 32'h0);
      chk("rst_data2", 32'(ad12), 32'h0);
      chk("rst_rspdata", 32'(rd1), 32'h0);
      chk("rst_busy3", 32'(busy3), 32'h0);
      chk("rst_rsp3", 32'(rv3), 32'h0);
      m_ptr  = 0;
      m_free = cyc;
      m_rsp  = -1;
      m_cnt  = 0;
    end else begin
      eb = (cyc < m_free);
      chk("busy", 32'(busy1), 32'(eb));
      er = 4'd0;
      if (!eb && v1 != 4'd0) begin
        g  = -1;
        bd = N;
        for (int i = 0; i < N; i++) begin
          d = (i - m_ptr + N) % N;
          if (v1[i] && d < bd) begin
            bd = d;
            g  = i;
            m_op = op1[i];
            m_a  = a1[i];
            m_b  = b1[i];
          end
        end
        er     = 4'd1 << g;
        m_val  = alu_fn(m_op, m_a, m_b);
        m_idx  = g;
        m_rsp  = cyc + LAT1 + 2;
        m_free = cyc + LAT1 + 3;
        m_ptr  = (g + 1) % N;
      end
      chk("ready", 32'(rdy1), 32'(er));
      if (eb) begin
        chk("alu_opcode", 32'(ao1), 32'(m_op));
        chk("alu_data_1", 32'(ad11), 32'(m_a));
        chk("alu_data_2", 32'(ad12), 32'(m_b));
      end else begin
        chk("alu_idle_op", 32'(ao1), 32'(RST));
      end
      ers = (cyc == m_rsp) ? (4'd1 << m_idx) : 4'd0;
      chk("rsp_valid", 32'(rv1), 32'(ers));
      if (cyc == m_rsp) chk("rsp_data", 32'(rd1), 32'(m_val));
      chk("op_count", 32'(cnt1), 32'(m_cnt));
      if (cyc == m_rsp) m_cnt = m_cnt + 16'd1;
    end
    for (int i = 0; i < N; i++) begin
      if (rdy1[i]) begin gq.push_back(i); gcq.push_back(cyc); end
      if (rv1[i]) begin
        rq.push_back(i); rcq.push_back(cyc); rdq.push_back(rd1);
      end
      if (rdy3[i]) begin g3q.push_back(i); g3cq.push_back(cyc); end
      if (rv3[i]) begin
        r3q.push_back(i); r3cq.push_back(cyc); r3dq.push_back(rd3);
      end
    end
    if (busy3 && rv3 == 4'd0 &&
        (ao3 != MOV || ad31 != 8'h5A || ad32 != 8'h77))
      viol3++;
    last_rdy1 = rdy1;
    last_rdy3 = rdy3;
  end

  bit auto_drop = 1'b1;

  task automatic step();
    @(posedge clk);
    #1;
    if (auto_drop) v1 = v1 & ~last_rdy1;
    v3 = v3 & ~last_rdy3;
  endtask

  task automatic wait_grants(int n, int budget, string nm);
    int t = 0;
    while (gq.size() < n && t < budget) begin step(); t++; end
    chk({nm, "_grant_wait"}, 32'(gq.size() >= n), 32'h1);
  endtask

  task automatic wait_rsps(int n, int budget, string nm);
    int t = 0;
    while (rq.size() < n && t < budget) begin step(); t++; end
    chk({nm, "_rsp_wait"}, 32'(rq.size() >= n), 32'h1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v1 = 4'd0;
    v3 = 4'd0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic single(int i, myopcode_t op, logic [7:0] a,
                        logic [7:0] b, logic [7:0] exp, string nm);
    int rb = rq.size();
    op1[i] = op;
    a1[i]  = a;
    b1[i]  = b;
    v1[i]  = 1'b1;
    wait_rsps(rb + 1, 20, nm);
    chk({nm, "_idx"}, 32'(rq[rb]), 32'(i));
    chk(nm, 32'(rdq[rb]), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gb, rb;
    int ord5 [5];
    logic [7:0] dat5 [5];
    ord5 = '{0, 1, 2, 3, 0};
    dat5 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    rst_n = 1'b0;
    v1 = 4'd0;
    v3 = 4'd0;
    for (int i = 0; i < N; i++) begin
      op1[i] = RST; a1[i] = 8'h00; b1[i] = 8'h00;
      op3[i] = RST; a3[i] = 8'h00; b3[i] = 8'h00;
    end
    repeat (2) @(negedge clk);
    chk("lit_rst_busy", 32'(busy1), 32'h0);
    chk("lit_rst_opcode", 32'(ao1), 32'(RST));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single ADD on requester 0
    gb = gq.size();
    rb = rq.size();
    op1[0] = ADD; a1[0] = 8'h12; b1[0] = 8'h34;
    v1 = 4'b0001;
    wait_rsps(rb + 1, 20, "add");
    chk("add_gidx", 32'(gq[gb]), 32'h0);
    chk("add_latency", 32'(rcq[rb] - gcq[gb]), 32'd3);
    chk("add_data", 32'(rdq[rb]), 32'h46);
    chk("add_count", 32'(cnt1), 32'h1);

    // all four held: strict rotation, 4 cycles apart
    do_reset();
    auto_drop = 1'b0;
    for (int i = 0; i < N; i++) begin
      op1[i] = ADD; a1[i] = 8'(i); b1[i] = 8'h10;
    end
    gb = gq.size();
    rb = rq.size();
    v1 = 4'b1111;
    wait_grants(gb + 5, 40, "rr");
    v1 = 4'b0000;
    wait_rsps(rb + 5, 20, "rr");
    for (int k = 0; k < 5; k++) begin
      chk("rr_order", 32'(gq[gb+k]), 32'(ord5[k]));
      chk("rr_rsp_idx", 32'(rq[rb+k]), 32'(ord5[k]));
      chk("rr_rsp_data", 32'(rdq[rb+k]), 32'(dat5[k]));
      if (k > 0) chk("rr_gap", 32'(gcq[gb+k] - gcq[gb+k-1]), 32'd4);
    end
    auto_drop = 1'b1;

    // pointer follows the last grant
    do_reset();
    for (int i = 0; i < N; i++) begin
      op1[i] = MOV; a1[i] = 8'h20 + 8'(i); b1[i] = 8'h00;
    end
    gb = gq.size();
    v1 = 4'b0100;
    wait_grants(gb + 1, 10, "ptr");
    v1 = 4'b1001;
    wait_grants(gb + 3, 30, "ptr");
    chk("ptr_g0", 32'(gq[gb]), 32'd2);
    chk("ptr_g1", 32'(gq[gb+1]), 32'd3);
    chk("ptr_g2", 32'(gq[gb+2]), 32'd0);
    wait_rsps(rq.size() + 1, 20, "ptr_drain");

    // width and wrap on requester 1
    single(1, ADD, 8'hFF, 8'h01, 8'h00, "add_wrap");
    single(1, LSH, 8'h3C, 8'h00, 8'hC0, "lsh");
    single(1, RSH, 8'h3C, 8'h00, 8'h03, "rsh");
    single(1, NOT, 8'h0F, 8'h00, 8'hF0, "not");
    single(1, XOR, 8'hAA, 8'hFF, 8'h55, "xor");
    single(3, SUB, 8'h10, 8'h20, 8'hF0, "sub_wrap");

    // reset while in WAIT drops the operation
    gb = gq.size();
    op1[2] = MOV; a1[2] = 8'hEE; b1[2] = 8'h00;
    v1 = 4'b0100;
    wait_grants(gb + 1, 10, "mid");
    rst_n = 1'b0;
    v1 = 4'b0000;
    rb = rq.size();
    @(negedge clk);
    chk("mid_busy", 32'(busy1), 32'h0);
    chk("mid_rsp", 32'(rv1), 32'h0);
    chk("mid_opcode", 32'(ao1), 32'(RST));
    chk("mid_count", 32'(cnt1), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      op1[i] = ADD; a1[i] = 8'h01; b1[i] = 8'(i);
    end
    gb = gq.size();
    v1 = 4'b1111;
    wait_rsps(rb + 4, 40, "post_rst");
    chk("post_rst_g0", 32'(gq[gb]), 32'd0);
    chk("post_rst_r0", 32'(rq[rb]), 32'd0);
    chk("post_rst_d0", 32'(rdq[rb]), 32'h01);
    chk("post_rst_r3", 32'(rq[rb+3]), 32'd3);
    step();
    chk("post_rst_count", 32'(cnt1), 32'd4);

    // ALU_LAT = 3 unit
    gb = g3q.size();
    rb = r3q.size();
    op3[0] = MOV; a3[0] = 8'h5A; b3[0] = 8'h77;
    v3 = 4'b0001;
    for (int t = 0; t < 30 && r3q.size() < rb + 1; t++) step();
    chk("lat3_rsp_seen", 32'(r3q.size() >= rb + 1), 32'h1);
    chk("lat3_gidx", 32'(g3q[gb]), 32'd0);
    chk("lat3_ridx", 32'(r3q[rb]), 32'd0);
    chk("lat3_latency", 32'(r3cq[rb] - g3cq[gb]), 32'd5);
    chk("lat3_data", 32'(r3dq[rb]), 32'h5A);
    chk("lat3_stable", 32'(viol3), 32'h0);
    step();
    chk("lat3_count", 32'(cnt3), 32'h1);
    chk("lat3_idle_op", 32'(ao3), 32'(RST));

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
